// File: rtl/posit_dec_pkg.sv
// posit_dec_pkg: shared widths, constants and the decoded-result record for the posit64 decoder.
package posit_dec_pkg;
    localparam int N       = 64;
    localparam int ES      = 4;
    localparam int K_W     = 7;
    localparam int FRAC_W  = 57;
    localparam int SCALE_W = 11;
    localparam logic [N-1:0] NAR = 64'h8000_0000_0000_0000;
    typedef struct packed {
        logic               tag;
        logic               sign;
        logic               zero;
        logic               nar;
        logic [K_W-1:0]     k;
        logic [ES-1:0]      exp;
        logic [FRAC_W-1:0]  frac;
        logic [SCALE_W-1:0] scale;
    } dec_t;
endpackage

// File: rtl/LDD.sv
// LDD: leading-digit detector; one-hot marks the first body bit that differs from the run's lead bit.
module LDD #(
    parameter int n = 64
) (
    input  logic [n-2:0] in,
    output logic [n-3:0] out,
    output logic         allone,
    output logic         allzero
);
    logic w_found;
    always_comb begin
        out     = '0;
        w_found = 1'b0;
        for (int i = n - 3; i >= 0; i--) begin
            if (!w_found && (in[i] != in[n-2])) begin
                out[i]  = 1'b1;
                w_found = 1'b1;
            end
        end
    end
    assign allone  = &in;
    assign allzero = ~|in;
endmodule

// File: rtl/posit_rr_arb2.sv
// posit_rr_arb2: two-way round-robin arbiter; the pointer flips away from whoever was just served.
module posit_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic [1:0] o_grant
);
    logic r_ptr;
    always_comb o_grant = (i_valid == 2'b11) ? (r_ptr ? 2'b10 : 2'b01) : i_valid;
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= 1'b0;
        else if (i_accept)
            r_ptr <= ~o_grant[1];
    end
endmodule

// File: rtl/posit_ldd_dec_ctrl.sv
// posit_ldd_dec_ctrl: two-requester, 3-stage posit64 (es=4) field decoder around one shared LDD.
module posit_ldd_dec_ctrl
    import posit_dec_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in0_valid,
    output logic               in0_ready,
    input  logic [N-1:0]       in0_data,
    input  logic               in1_valid,
    output logic               in1_ready,
    input  logic [N-1:0]       in1_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_tag,
    output logic               out_sign,
    output logic               out_zero,
    output logic               out_nar,
    output logic [K_W-1:0]     out_k,
    output logic [ES-1:0]      out_exp,
    output logic [FRAC_W-1:0]  out_frac,
    output logic [SCALE_W-1:0] out_scale
);
    logic                w_adv, w_acc, w_sign, w_zero, w_nar, w_allone, w_allzero, w_special;
    logic [1:0]          w_grant;
    logic [N-2:0]        w_body;
    logic [N-3:0]        w_oh;
    logic [5:0]          w_j;
    logic [K_W-1:0]      w_m, w_k;
    logic [ES+FRAC_W-1:0] w_rem;
    dec_t                w_dec;
    logic                r_s1_v, r_s1_tag;
    logic [N-1:0]        r_s1_p;
    logic                r_s2_v, r_s2_tag, r_s2_sign, r_s2_zero, r_s2_nar, r_s2_allone, r_s2_allzero;
    logic [N-2:0]        r_s2_body;
    logic [N-3:0]        r_s2_oh;
    logic                r_out_v;
    dec_t                r_out;

    assign w_adv     = !r_out_v || out_ready;
    assign in0_ready = w_adv && w_grant[0] && !rst;
    assign in1_ready = w_adv && w_grant[1] && !rst;
    assign w_acc     = in0_ready || in1_ready;

    posit_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_valid  ({in1_valid, in0_valid}),
        .i_accept (w_acc),
        .o_grant  (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_s1_tag <= 1'b0;
            r_s1_p   <= '0;
        end else if (w_adv) begin
            r_s1_v   <= w_acc;
            r_s1_tag <= in1_ready;
            r_s1_p   <= in1_ready ? in1_data : in0_data;
        end
    end

    // Negative posits are decoded from their two's complement magnitude.
    assign w_sign = r_s1_p[N-1];
    assign w_zero = (r_s1_p == '0);
    assign w_nar  = (r_s1_p == NAR);
    assign w_body = (N-1)'(w_sign ? -r_s1_p : r_s1_p);

    LDD #(.n(N)) u_ldd (
        .in      (w_body),
        .out     (w_oh),
        .allone  (w_allone),
        .allzero (w_allzero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v       <= 1'b0;
            r_s2_tag     <= 1'b0;
            r_s2_sign    <= 1'b0;
            r_s2_zero    <= 1'b0;
            r_s2_nar     <= 1'b0;
            r_s2_allone  <= 1'b0;
            r_s2_allzero <= 1'b0;
            r_s2_body    <= '0;
            r_s2_oh      <= '0;
        end else if (w_adv) begin
            r_s2_v       <= r_s1_v;
            r_s2_tag     <= r_s1_tag;
            r_s2_sign    <= w_sign;
            r_s2_zero    <= w_zero;
            r_s2_nar     <= w_nar;
            r_s2_allone  <= w_allone;
            r_s2_allzero <= w_allzero;
            r_s2_body    <= w_body;
            r_s2_oh      <= w_oh;
        end
    end

    always_comb begin
        w_j = '0;
        for (int i = 0; i < N - 2; i++)
            if (r_s2_oh[i]) w_j = w_j | 6'(i);
    end

    // Shifting by m-1 and truncating to 61 bits drops the regime run and its terminator.
    assign w_m       = (r_s2_allone || r_s2_allzero) ? 7'd63 : 7'd62 - {1'b0, w_j};
    assign w_k       = r_s2_body[N-2] ? w_m - 7'd1 : 7'd0 - w_m;
    assign w_rem     = (w_m >= 7'd62) ? '0 : (ES+FRAC_W)'(r_s2_body << (w_m - 7'd1));
    assign w_special = r_s2_zero || r_s2_nar;

    always_comb begin
        w_dec       = '0;
        w_dec.tag   = r_s2_tag;
        w_dec.sign  = r_s2_nar || (r_s2_sign && !r_s2_zero);
        w_dec.zero  = r_s2_zero;
        w_dec.nar   = r_s2_nar;
        w_dec.k     = w_special ? '0 : w_k;
        w_dec.exp   = w_special ? '0 : w_rem[ES+FRAC_W-1 -: ES];
        w_dec.frac  = w_special ? '0 : w_rem[FRAC_W-1:0];
        w_dec.scale = w_special ? '0 : {w_k, w_rem[ES+FRAC_W-1 -: ES]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_v <= 1'b0;
            r_out   <= '0;
        end else if (w_adv) begin
            r_out_v <= r_s2_v;
            r_out   <= w_dec;
        end
    end

    assign out_valid = r_out_v;
    assign out_tag   = r_out.tag;
    assign out_sign  = r_out.sign;
    assign out_zero  = r_out.zero;
    assign out_nar   = r_out.nar;
    assign out_k     = r_out.k;
    assign out_exp   = r_out.exp;
    assign out_frac  = r_out.frac;
    assign out_scale = r_out.scale;
endmodule

// File: tb/tb_posit_ldd_dec_ctrl.sv
// tb_posit_ldd_dec_ctrl: directed checks of decode values, arbitration, stall and reset behaviour.
module tb_posit_ldd_dec_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in0_valid, in0_ready, in1_valid, in1_ready;
    logic [63:0] in0_data, in1_data;
    logic        out_valid, out_ready, out_tag, out_sign, out_zero, out_nar;
    logic [6:0]  out_k;
    logic [3:0]  out_exp;
    logic [56:0] out_frac;
    logic [10:0] out_scale;
    int          n_chk = 0;
    int          n_pass = 0;

    posit_ldd_dec_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .out_sign  (out_sign),
        .out_zero  (out_zero),
        .out_nar   (out_nar),
        .out_k     (out_k),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_scale (out_scale)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && dut.r_s2_v)
            assert ($onehot(dut.r_s2_oh) || dut.r_s2_allone || dut.r_s2_allzero)
                else $error("ldd one-hot invariant broken: %h", dut.r_s2_oh);

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_chk++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, got, exp_v);
    endtask

    // posit 0 1 0 eeee 0...: regime k=0, exponent e, scale e
    function automatic logic [63:0] mk(input logic [3:0] e);
        return {3'b010, e, 57'b0};
    endfunction

    task automatic run_one(input int req, input logic [63:0] p, input logic tg, sg, zr, nr,
                           input logic [6:0] k_e, input logic [3:0] ex_e,
                           input logic [56:0] fr_e, input logic [10:0] sc_e);
        int lat;
        @(posedge clk); #1;
        if (req == 0) begin in0_valid = 1'b1; in0_data = p; end
        else begin in1_valid = 1'b1; in1_data = p; end
        out_ready = 1'b1;
        #1 chk("ready", req == 0 ? in0_ready : in1_ready, 1);
        @(posedge clk); #1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 3);
        chk("tag", out_tag, tg);
        chk("sign", out_sign, sg);
        chk("zero", out_zero, zr);
        chk("nar", out_nar, nr);
        chk("k", out_k, k_e);
        chk("exp", out_exp, ex_e);
        chk("frac", out_frac, fr_e);
        chk("scale", out_scale, sc_e);
    endtask

    initial begin
        int i0, i1, c, nres;
        int gseq[$];
        rst = 1'b1;
        in0_valid = 1'b1;
        in1_valid = 1'b0;
        in0_data = 64'h4000_0000_0000_0000;
        in1_data = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready0", in0_ready, 0);
        chk("rst_ready1", in1_ready, 0);
        chk("rst_k", out_k, 0);
        chk("rst_scale", out_scale, 0);
        chk("rst_frac", out_frac, 0);
        rst = 1'b0;
        in0_valid = 1'b0;

        run_one(0, 64'h4000_0000_0000_0000, 0, 0, 0, 0, 7'd0, 4'd0, 57'd0, 11'd0);
        run_one(1, 64'h5000_0000_0000_0000, 1, 0, 0, 0, 7'd0, 4'd8, 57'd0, 11'd8);
        run_one(0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 7'd62, 4'd0, 57'd0, 11'd992);
        run_one(0, 64'h0000_0000_0000_0001, 0, 0, 0, 0, 7'(-62), 4'd0, 57'd0, 11'(-992));
        run_one(0, 64'hC000_0000_0000_0000, 0, 1, 0, 0, 7'd0, 4'd0, 57'd0, 11'd0);
        run_one(0, 64'h0000_0000_0000_0000, 0, 0, 1, 0, 7'd0, 4'd0, 57'd0, 11'd0);
        run_one(0, 64'h8000_0000_0000_0000, 0, 1, 0, 1, 7'd0, 4'd0, 57'd0, 11'd0);
        run_one(1, 64'h4C80_0000_0000_0000, 1, 0, 0, 0, 7'd0, 4'd6, 57'h80_0000_0000_0000, 11'd6);
        run_one(0, 64'h0C00_0000_0000_0000, 0, 0, 0, 0, 7'(-3), 4'd8, 57'd0, 11'(-40));
        run_one(1, 64'hB380_0000_0000_0000, 1, 1, 0, 0, 7'd0, 4'd6, 57'h80_0000_0000_0000, 11'd6);
        run_one(0, 64'h7A00_0000_0000_0000, 0, 0, 0, 0, 7'd3, 4'd8, 57'd0, 11'd56);

        // dual requesters, output stalled during cycles 4..8
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        i0 = 0; i1 = 0; c = 0; nres = 0;
        while (nres < 8 && c < 60) begin
            c++;
            in0_valid = (i0 < 4);
            in0_data  = mk(4'(i0 + 1));
            in1_valid = (i1 < 4);
            in1_data  = mk(4'(i1 + 9));
            out_ready = !(c >= 4 && c <= 8);
            #1;
            if (c >= 4 && c <= 8) begin
                chk("stall_ready0", in0_ready, 0);
                chk("stall_ready1", in1_ready, 0);
                chk("stall_valid", out_valid, 1);
                chk("stall_tag", out_tag, 0);
                chk("stall_exp", out_exp, 1);
            end
            if (in0_ready) begin gseq.push_back(0); i0++; end
            if (in1_ready) begin gseq.push_back(1); i1++; end
            if (out_valid && out_ready) begin
                chk("dual_tag", out_tag, nres % 2);
                chk("dual_exp", out_exp, nres / 2 + 1 + 8 * (nres % 2));
                nres++;
            end
            @(posedge clk); #1;
        end
        chk("dual_results", nres, 8);
        chk("dual_grants", gseq.size(), 8);
        foreach (gseq[i]) chk("grant_order", gseq[i], i % 2);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;

        // two items from requester 0 in flight leave the pointer on requester 1, then reset
        @(posedge clk); #1;
        in0_valid = 1'b1;
        in0_data  = mk(4'd5);
        #1 chk("mid_ready_a", in0_ready, 1);
        @(posedge clk); #1;
        in0_data = mk(4'd6);
        #1 chk("mid_ready_b", in0_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        in0_data = mk(4'd7);
        in1_valid = 1'b1;
        in1_data = mk(4'd14);
        #1;
        chk("rst_gate0", in0_ready, 0);
        chk("rst_gate1", in1_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_valid", out_valid, 0);
        #1;
        chk("post_rst_grant0", in0_ready, 1);
        chk("post_rst_grant1", in1_ready, 0);
        @(posedge clk); #1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        chk("flush_a", out_valid, 0);
        @(posedge clk); #1;
        chk("flush_b", out_valid, 0);
        @(posedge clk); #1;
        chk("post_rst_out", out_valid, 1);
        chk("post_rst_tag", out_tag, 0);
        chk("post_rst_exp", out_exp, 7);

        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/posit_ldd_dec_ctrl.md
Name: posit_ldd_dec_ctrl

Overview:
- Two-requester, 3-stage pipelined posit64 (es=4) field-decode controller built around one shared leading-digit-detector instance (`LDD`, n=64).
- Arbitrates requesters round-robin and handles two's-complement of negative posits.
- Sequences the LDD and turns its one-hot run-terminator output into regime, exponent, fraction and scale fields.
- Output uses a valid/ready interface and carries the requester tag.

Parameters:
- N, 64, posit width; fixed at 64 because the LDD instance is sized for 64.
- ES, 4, exponent field width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in0_valid  in  1  requester 0 has a posit.
- in0_ready  out  1  requester 0 posit accepted this cycle.
- in0_data  in  64  requester 0 posit.
- in1_valid  in  1  requester 1 has a posit.
- in1_ready  out  1  requester 1 posit accepted this cycle.
- in1_data  in  64  requester 1 posit.
- out_valid  out  1  decoded result available.
- out_ready  in  1  consumer accepts the result.
- out_tag  out  1  requester id (0 or 1).
- out_sign  out  1  posit sign.
- out_zero  out  1  input was 0x0.
- out_nar  out  1  input was 0x8000_0000_0000_0000.
- out_k  out  7  signed regime value, range -63..62.
- out_exp  out  4  exponent; bits cut off by the regime read as 0.
- out_frac  out  57  fraction, left-aligned, zero-padded.
- out_scale  out  11  signed scale k*16+exp, range -1008..1007.

Behaviour:
- Reset:
  - Clears all stage valids, out_valid, in0_ready and in1_ready, and the RR pointer (pointer=0, requester 0 favoured).
  - All data outputs reset to 0.
  - Reset mid-stream discards in-flight items.
- Advance:
  - Global pipeline enable: adv = !out_valid || out_ready. All stages shift together when adv=1 and hold when adv=0.
  - inX_ready = adv && grantX. ready is never asserted while adv=0.
- Arbitration:
  - One valid requester: it is granted.
  - Both valid: the pointer's requester is granted.
  - After any accepted transfer the pointer moves to the other requester.
  - Sustained dual requests therefore alternate 0,1,0,1.
  - Grant is combinational from valids and pointer.
- S1 (capture):
  - Registers p, tag and v.
  - sign=p[63]; zero=(p==0); nar=(p==1<<63).
  - a = sign ? -p : p, in 64-bit two's complement.
- S2 (LDD):
  - Drives LDD.in = a[62:0] (body).
  - Registers one-hot out[61:0], allone, allzero, body, flags and tag.
- S3 (extract):
  - Run length m = allone|allzero ? 63 : 62-j, where j = index of the set bit in out.
  - k = body[62] ? m-1 : -m.
  - Remaining bits after the regime and terminator are shifted left (shift = m+1, saturating so that nothing remains when m≥62).
  - exp = top 4 of the remainder; frac = next 57 bits.
  - scale = k*16 + exp.
  - If zero or nar: k, exp, frac and scale are forced to 0; sign is 0 for zero and 1 for nar.
- Latency: 3 cycles from the accept edge to out_valid with no stall; throughput 1 per cycle.
- Stall: output fields are stable while out_valid && !out_ready. No item is lost or duplicated.
- Simultaneous out_ready and a new input acceptance in the same cycle is legal and full-rate.
- out_valid deasserts only after a handshake with an empty S2.
- out one-hot invariant: exactly one bit is set unless allone or allzero. A bench assertion flags violations.

Decomposition:
- posit_dec_pkg holds:
  - N=64, ES=4.
  - Widths K_W=7, FRAC_W=57, SCALE_W=11.
  - NAR constant 64'h8000_0000_0000_0000.
  - A decoded-result struct: tag, sign, zero, nar, k, exp, frac, scale.
- Sub-module posit_rr_arb2: 2-way round-robin arbiter with pointer register, valid in, grant out, and an update-on-accept input.
- The existing LDD is instantiated unmodified with n=64.
- One-hot-to-index encoding and field extraction live in the top module.

Test Plan:
- in0 = 0x4000_0000_0000_0000 alone → after 3 cycles: tag=0, sign=0, k=0, exp=0, frac=0, scale=0.
- in1 = 0x5000_0000_0000_0000 → k=0, exp=8, frac=0, scale=8, tag=1.
- in0 = 0x7FFF_FFFF_FFFF_FFFF → allone path: k=62, exp=0, frac=0, scale=992.
- in0 = 0x0000_0000_0000_0001 → k=-62, exp=0, scale=-992.
- in0 = 0xC000_0000_0000_0000 → sign=1, k=0, scale=0.
- in0 = 0x0 → zero=1, k=exp=frac=scale=0.
- in0 = 0x8000_0000_0000_0000 → nar=1, sign=1, k=exp=frac=scale=0.
- Dual requests, then stall:
  - Stimulus: both requesters valid for 8 cycles with distinct posits; out_ready held low for cycles 4-8.
  - Required: grants alternate 0,1,0,1; in0_ready and in1_ready stay low during the stall; output holds stable.
  - After release: all 8 results appear in grant order with correct tags, none lost.
- Reset mid-stream: assert rst on the cycle after 2 items are in flight → next cycle out_valid=0, pointer=0; the first post-reset dual request grants requester 0.
